alu_arbiter_seq: RTL and testbench
==================================

Name: alu_arbiter_seq

Overview:
- Shares one `alub` instance (8-bit ALU: 3-bit ALU_Sel, Result, NZVC flags N=3, Z=2, V=1, C=0) between two requesters, e.g. the core datapath and the address/loop unit.
- Arbitrates, latches the winner's operands, runs the ALU for one cycle, then returns a registered result and flags tagged with the requester ID.
- Keeps an architectural NZVC status register that only completed operations update.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with requester 0 always winning.
- FLAGS_RST, 4'b0000, reset and clear value of the status register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  2  per-requester request level; req[i] stays high until gnt[i] is seen.
- op0  input  3  requester 0 ALU_Sel code.
- a0  input  8  requester 0 operand A.
- b0  input  8  requester 0 operand B.
- op1  input  3  requester 1 ALU_Sel code.
- a1  input  8  requester 1 operand A.
- b1  input  8  requester 1 operand B.
- flags_clr  input  1  synchronous clear of the status register.
- gnt  output  2  one-hot, one-cycle pulse: the request was captured.
- busy  output  1  high while in EXEC.
- done  output  1  one-cycle pulse: result and nzvc are valid.
- done_id  output  1  requester that owns the completing result.
- result  output  8  registered ALU Result; held until the next done.
- nzvc  output  4  registered ALU NZVC of the completing operation; held.
- flags  output  4  status register: NZVC of the last completed operation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; gnt=0, busy=0, done=0, done_id=0, result=0, nzvc=0, flags=FLAGS_RST.
  - Internal op/A/B latches cleared; last_id=1, so req0 wins the first tie.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - If req==00, stay in IDLE; gnt=00.
  - Otherwise pick the winner w:
    - single request: that requester.
    - both requesting, ARB_MODE=0: w = ~last_id.
    - both requesting, ARB_MODE=1: w = 0.
  - At the edge: latch op_w/a_w/b_w into internal registers; gnt<=onehot(w); id<=w; last_id<=w; state<=EXEC.
- EXEC (exactly one cycle):
  - busy=1 and gnt is high this cycle. req is ignored.
  - The ALU is driven only from the latched registers, never from live inputs.
  - At the edge: result<=Result; nzvc<=NZVC; flags<=NZVC; done_id<=id; done<=1; gnt<=00; state<=IDLE.
- Requester protocol:
  - Hold op/a/b stable while req is high and gnt is low.
  - Drop req, or present a new operation, on the edge where gnt is sampled high.
  - A requester that re-asserts immediately competes in the next IDLE cycle.
- Timing:
  - Latency: capture edge to done = 2 edges.
  - Sustained throughput: 1 operation per 2 cycles.
  - done and a new capture may occur on the same cycle.
- ALU semantics are exactly those of `alub`. Codes 000 to 111 are all legal. No X reaches the outputs because the latches are reset.
- flags_clr:
  - Sets flags to FLAGS_RST at the edge.
  - If it coincides with the EXEC-to-IDLE edge, the completion value wins.
  - result and nzvc are unaffected.
- Reset mid-EXEC: the operation is discarded; no done pulse; round-robin history restarts with last_id=1.
- done is a pulse, not a level: done=0 in every cycle except the one following EXEC.

Test Plan:
- Requester 0 issues ADD (000), a0=0x7F, b0=0x01 → gnt=01 one cycle after capture; done 2 edges after capture; result=0x80, nzvc=1010, flags=1010, done_id=0.
- Requester 1 issues SUB (010), a1=0x00, b1=0x01 → result=0xFF, nzvc=1001, done_id=1. Then SUB with a1=0x05, b1=0x05 → result=0x00, nzvc=0100.
- From reset, req=11 held continuously in ARB_MODE=0 → grants alternate 01, 10, 01, 10 on IDLE cycles. With ARB_MODE=1 and req0 held → only 01 is ever granted.
- INC (001) with a0=0xFF → result=0x00, nzvc=0101. Asserting flags_clr on the completion edge → flags=0101. Asserting it one cycle later → flags=0000, nzvc still 0101.
- rst_n pulled low during EXEC of ADD 0x10+0x20 → outputs zero immediately, no done pulse, flags=FLAGS_RST. A following req=11 grants requester 0 first.
- Toggle a0/b0 during EXEC after capture → result still reflects the captured operands.

Source files
------------

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: two-requester arbiter sharing one 8-bit NZVC ALU.
// Flow: capture the winner's operands, execute for one cycle, return a tagged registered result.
module alub (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] ALU_Sel,
  output logic [7:0] Result,
  output logic [3:0] NZVC
);
  logic [8:0] w_add, w_sub, w_inc, w_dec, w_wide;
  logic       w_v;
  assign w_add = {1'b0, A} + {1'b0, B};
  assign w_sub = {1'b0, A} - {1'b0, B};
  assign w_inc = {1'b0, A} + 9'd1;
  assign w_dec = {1'b0, A} - 9'd1;
  // Carry of SUB/DEC is the borrow out of bit 7.
  always_comb begin
    w_wide = 9'd0;
    w_v    = 1'b0;
    case (ALU_Sel)
      3'b000: begin w_wide = w_add; w_v = (A[7] == B[7]) && (w_add[7] != A[7]); end
      3'b001: begin w_wide = w_inc; w_v = ~A[7] & w_inc[7]; end
      3'b010: begin w_wide = w_sub; w_v = (A[7] != B[7]) && (w_sub[7] != A[7]); end
      3'b011: begin w_wide = w_dec; w_v = A[7] & ~w_dec[7]; end
      3'b100: w_wide = {1'b0, A & B};
      3'b101: w_wide = {1'b0, A | B};
      3'b110: w_wide = {1'b0, A ^ B};
      default: w_wide = {1'b0, ~A};
    endcase
  end
  assign Result = w_wide[7:0];
  assign NZVC   = {w_wide[7], w_wide[7:0] == 8'd0, w_v, w_wide[8]};
endmodule

module alu_arbiter_seq #(
  parameter int         ARB_MODE  = 0,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [2:0] op0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [2:0] op1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic       flags_clr,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [7:0] result,
  output logic [3:0] nzvc,
  output logic [3:0] flags
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t     r_state, w_next;
  logic [2:0] r_op;
  logic [7:0] r_a, r_b, r_result, w_res;
  logic [3:0] r_nzvc, r_flags, w_nzvc;
  logic [1:0] r_gnt;
  logic       r_id, r_last_id, r_done, r_done_id, w_win, w_cap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // On a tie, round-robin favours the requester that did not win last time.
  always_comb begin
    w_cap  = (r_state == IDLE) && (req != 2'b00);
    w_win  = (req == 2'b11) ? ((ARB_MODE != 0) ? 1'b0 : ~r_last_id) : req[1];
    w_next = w_cap ? EXEC : IDLE;
  end
  alub u_alu (
    .A      (r_a),
    .B      (r_b),
    .ALU_Sel(r_op),
    .Result (w_res),
    .NZVC   (w_nzvc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= 3'd0;
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_id      <= 1'b0;
      r_last_id <= 1'b1;
      r_gnt     <= 2'b00;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= 8'd0;
      r_nzvc    <= 4'd0;
      r_flags   <= FLAGS_RST;
    end else begin
      r_gnt  <= 2'b00;
      r_done <= 1'b0;
      if (w_cap) begin
        r_op      <= w_win ? op1 : op0;
        r_a       <= w_win ? a1 : a0;
        r_b       <= w_win ? b1 : b0;
        r_gnt     <= w_win ? 2'b10 : 2'b01;
        r_id      <= w_win;
        r_last_id <= w_win;
      end
      if (r_state == EXEC) begin
        r_result  <= w_res;
        r_nzvc    <= w_nzvc;
        r_flags   <= w_nzvc;
        r_done_id <= r_id;
        r_done    <= 1'b1;
      end else if (flags_clr) r_flags <= FLAGS_RST;
    end
  end
  assign gnt     = r_gnt;
  assign busy    = (r_state == EXEC);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign result  = r_result;
  assign nzvc    = r_nzvc;
  assign flags   = r_flags;
endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: randomized and directed checks of the shared-ALU arbiter against an arithmetic model.
module tb_alu_arbiter_seq;
  logic       clk = 0, rst_n = 0, flags_clr = 0;
  logic [1:0] req = 0;
  logic [2:0] op0 = 0, op1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [1:0] gnt, gnt_fp;
  logic       busy, busy_fp, done, done_fp, done_id, done_id_fp;
  logic [7:0] result, result_fp;
  logic [3:0] nzvc, nzvc_fp, flags, flags_fp;
  logic [3:0] exp_flags = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_arbiter_seq #(.ARB_MODE(0), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op0(op0), .a0(a0), .b0(b0),
    .op1(op1), .a1(a1), .b1(b1), .flags_clr(flags_clr), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .result(result), .nzvc(nzvc), .flags(flags));

  alu_arbiter_seq #(.ARB_MODE(1), .FLAGS_RST(4'b1010)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .op0(op0), .a0(a0), .b0(b0),
    .op1(op1), .a1(a1), .b1(b1), .flags_clr(flags_clr), .gnt(gnt_fp), .busy(busy_fp),
    .done(done_fp), .done_id(done_id_fp), .result(result_fp), .nzvc(nzvc_fp), .flags(flags_fp));

  // Returns {result, N, Z, V, C} computed with integer arithmetic.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, s, ss;
    logic [7:0] r;
    logic v, c;
    ua = int'(a); ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    s = 0; ss = 0; v = 0; c = 0;
    case (op)
      3'd0: begin s = ua + ub; ss = sa + sb; end
      3'd1: begin s = ua + 1;  ss = sa + 1;  end
      3'd2: begin s = ua - ub; ss = sa - sb; end
      3'd3: begin s = ua - 1;  ss = sa - 1;  end
      default: ;
    endcase
    if (op < 3'd4) begin
      r = s[7:0];
      c = (s > 255) || (s < 0);
      v = (ss > 127) || (ss < -128);
    end else r = (op == 3'd4) ? (a & b) : (op == 3'd5) ? (a | b) : (op == 3'd6) ? (a ^ b) : ~a;
    return {r, r[7], r == 8'd0, v, c};
  endfunction

  // One complete transaction; operands are scrambled right after the grant.
  task automatic issue(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit clr);
    logic [11:0] e;
    int n;
    e = model(op, a, b);
    n = 0;
    if (id) begin op1 = op; a1 = a; b1 = b; end
    else begin op0 = op; a0 = a; b0 = b; end
    req[id] = 1'b1;
    @(negedge clk);
    while (gnt == 2'b00 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (gnt !== (id ? 2'b10 : 2'b01) || busy !== 1'b1) begin
      bad++;
      $display("FAIL grant id=%0d: got gnt=%b busy=%b want gnt=%b busy=1", id, gnt, busy, id ? 2'b10 : 2'b01);
    end
    req[id] = 1'b0;
    op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
    op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    flags_clr = clr;
    @(negedge clk);
    flags_clr = 1'b0;
    exp_flags = e[3:0];
    total++;
    if ({done, done_id, result, nzvc, flags} !== {1'b1, id, e, exp_flags}) begin
      bad++;
      $display("FAIL op=%b a=%h b=%h id=%0d: got done=%b id=%b res=%h nzvc=%b flags=%b want res=%h nzvc=%b flags=%b",
               op, a, b, id, done, done_id, result, nzvc, flags, e[11:4], e[3:0], exp_flags);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({gnt, busy, done, done_id, result, nzvc, flags} !== 19'd0) begin
      bad++;
      $display("FAIL reset: got gnt=%b busy=%b done=%b id=%b res=%h nzvc=%b flags=%b want all zero",
               gnt, busy, done, done_id, result, nzvc, flags);
    end
    total++;
    if (flags_fp !== 4'b1010 || busy_fp !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags_rst: got flags=%b busy=%b want 1010 0", flags_fp, busy_fp);
    end
    rst_n = 1;
    exp_flags = 0;
  endtask

  task automatic test_directed;
    issue(0, 3'b000, 8'h7F, 8'h01, 0);
    issue(1, 3'b010, 8'h00, 8'h01, 0);
    issue(1, 3'b010, 8'h05, 8'h05, 0);
    issue(0, 3'b011, 8'h80, 8'h00, 0);
    issue(1, 3'b111, 8'h0F, 8'h00, 0);
  endtask

  task automatic test_flags_clr;
    issue(0, 3'b001, 8'hFF, 8'h00, 1);
    flags_clr = 1;
    @(negedge clk);
    flags_clr = 0;
    total++;
    if (flags !== 4'b0000 || nzvc !== 4'b0101 || done !== 1'b0) begin
      bad++;
      $display("FAIL flags_clr: got flags=%b nzvc=%b done=%b want 0000 0101 0", flags, nzvc, done);
    end
    exp_flags = 0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      issue(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back;
    logic [1:0] want;
    logic       last;
    int grants, fp_grants;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req = 2'b11;
    want = 2'b01; grants = 0; fp_grants = 0; last = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        total++;
        if (done_id !== last) begin
          bad++;
          $display("FAIL rr_done_id: got %b want %b", done_id, last);
        end
      end
      if (gnt != 2'b00) begin
        total++;
        if (gnt !== want) begin
          bad++;
          $display("FAIL rr_gnt #%0d: got %b want %b", grants, gnt, want);
        end
        last = gnt[1];
        want = ~want;
        grants++;
      end
      if (gnt_fp != 2'b00) begin
        total++;
        fp_grants++;
        if (gnt_fp !== 2'b01) begin
          bad++;
          $display("FAIL fixed_gnt: got %b want 01", gnt_fp);
        end
      end
    end
    total++;
    if (grants < 9 || fp_grants < 9) begin
      bad++;
      $display("FAIL grant_rate: got rr=%0d fixed=%0d want >=9 each", grants, fp_grants);
    end
    req = 2'b00;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_flags = 0;
  endtask

  task automatic test_reset_mid;
    issue(0, 3'b000, 8'h7F, 8'h01, 0);
    op0 = 3'b000; a0 = 8'h10; b0 = 8'h20;
    req = 2'b01;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_gnt: got gnt=%b busy=%b want 01 1", gnt, busy);
    end
    req = 2'b00;
    #2 rst_n = 0;
    #1;
    total++;
    if ({gnt, busy, done, done_id, result, nzvc, flags} !== 19'd0) begin
      bad++;
      $display("FAIL mid_reset: got gnt=%b busy=%b done=%b res=%h nzvc=%b flags=%b want all zero",
               gnt, busy, done, result, nzvc, flags);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || result !== 8'h00) begin
      bad++;
      $display("FAIL mid_no_done: got done=%b res=%h want 0 00", done, result);
    end
    req = 2'b11;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL mid_rr_restart: got %b want 01", gnt);
    end
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_flags_clr;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
